// File: rtl/iot_alu_pkg.sv
// Shared opcodes, FSM states and flag bundle for the sequential IoT ALU.
// Optional macro: IOT_ALU_ACC_SAT_EN (signed saturating MAC accumulator).
package iot_alu_pkg;

   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_SUB    = 4'h1;
   localparam logic [3:0] OP_AND    = 4'h2;
   localparam logic [3:0] OP_OR     = 4'h3;
   localparam logic [3:0] OP_SLT    = 4'h4;
   localparam logic [3:0] OP_MAC    = 4'h5;
   localparam logic [3:0] OP_ANDN   = 4'h6;
   localparam logic [3:0] OP_ORN    = 4'h7;
   localparam logic [3:0] OP_SLEEP  = 4'h8;
   localparam logic [3:0] OP_WAKE   = 4'h9;
   localparam logic [3:0] OP_MUL    = 4'hA;
   localparam logic [3:0] OP_CLRACC = 4'hB;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_SLEEP = 2'd2
   } state_t;

   typedef struct packed {
      logic zero;
      logic negative;
      logic carry;
      logic overflow;
   } alu_flags_t;

   function automatic logic is_mul_op(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_MAC);
   endfunction

endpackage

// File: rtl/iot_mul_iter.sv
// Iterative shift-add multiplier, MUL_BPC multiplier bits per cycle.
// done is held until the cycle after it is seen, then the unit idles.
module iot_mul_iter
   import iot_alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_BPC = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int STEPS = WIDTH / MUL_BPC;
   localparam int CW    = $clog2(STEPS + 1);

   logic             busy;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc_p;
   logic [WIDTH-1:0] digit;
   logic [WIDTH-1:0] partial;

   assign digit   = WIDTH'(mplier[MUL_BPC-1:0]);
   assign partial = mcand * digit;
   assign done    = busy && (cnt == CW'(STEPS));
   assign product = acc_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc_p  <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= '0;
         mcand  <= a;
         mplier <= b;
         acc_p  <= '0;
      end else if (done) begin
         busy   <= 1'b0;
      end else if (busy) begin
         acc_p  <= acc_p + partial;
         mcand  <= mcand << MUL_BPC;
         mplier <= mplier >> MUL_BPC;
         cnt    <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/iot_alu_seq.sv
// Sequential IoT ALU: valid/ready handshakes, iterative MUL/MAC, SLEEP/WAKE.
// Optional macro: IOT_ALU_ACC_SAT_EN (signed saturating MAC accumulator).
module iot_alu_seq
   import iot_alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_BPC = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             sleeping
);

   localparam int MSB = WIDTH - 1;

   state_t           state;
   logic             sleep_pend;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] acc;
   alu_flags_t       flags_q;

   logic             fire_in;
   logic             fire_out;
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] prod;

   logic             sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   alu_flags_t       alu_flags;

   logic [WIDTH-1:0] mac_acc;
   logic             mac_ovf;
   logic [WIDTH-1:0] busy_res;
   alu_flags_t       busy_flags;

   assign zero     = flags_q.zero;
   assign negative = flags_q.negative;
   assign carry    = flags_q.carry;
   assign overflow = flags_q.overflow;

   // A pending SLEEP result blocks new work until it is consumed.
   always_comb begin
      in_ready = 1'b0;
      case (state)
         ST_IDLE:  in_ready = !sleep_pend && (!out_valid || out_ready);
         ST_SLEEP: in_ready = 1'b1;
         default:  in_ready = 1'b0;
      endcase
   end

   assign fire_in   = in_valid && in_ready;
   assign fire_out  = out_valid && out_ready;
   assign mul_start = fire_in && (state == ST_IDLE) && is_mul_op(op);

   iot_mul_iter #(
      .WIDTH   (WIDTH),
      .MUL_BPC (MUL_BPC)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (prod)
   );

   assign sub   = (op == OP_SUB);
   assign b_eff = sub ? ~b : b;
   assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

   always_comb begin
      alu_res   = '0;
      alu_flags = '0;
      case (op)
         OP_ADD, OP_SUB: begin
            alu_res         = sum[MSB:0];
            alu_flags.carry = sum[WIDTH];
            alu_flags.overflow = (sub ? (a[MSB] != b[MSB])
                                      : (a[MSB] == b[MSB]))
                                 && (sum[MSB] != a[MSB]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
         OP_ANDN: alu_res = a & ~b;
         OP_ORN:  alu_res = a | ~b;
         OP_WAKE: alu_res = a;
         default: alu_res = '0;
      endcase
      alu_flags.zero     = (alu_res == '0);
      alu_flags.negative = alu_res[MSB];
   end

`ifdef IOT_ALU_ACC_SAT_EN
   logic [WIDTH:0] ssum;

   assign ssum = {acc[MSB], acc} + {prod[MSB], prod};

   always_comb begin
      mac_acc = ssum[MSB:0];
      mac_ovf = 1'b0;
      if (ssum[WIDTH] != ssum[MSB]) begin
         mac_ovf = 1'b1;
         mac_acc = ssum[WIDTH] ? {1'b1, {MSB{1'b0}}}
                               : {1'b0, {MSB{1'b1}}};
      end
   end
`else
   assign mac_acc = acc + prod;
   assign mac_ovf = 1'b0;
`endif

   always_comb begin
      busy_res            = (op_q == OP_MAC) ? mac_acc : prod;
      busy_flags          = '0;
      busy_flags.zero     = (busy_res == '0);
      busy_flags.negative = busy_res[MSB];
      busy_flags.overflow = (op_q == OP_MAC) && mac_ovf;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         sleep_pend <= 1'b0;
         op_q       <= '0;
         acc        <= '0;
         result     <= '0;
         flags_q    <= '0;
         out_valid  <= 1'b0;
         sleeping   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (fire_out) begin
                  out_valid <= 1'b0;
                  if (sleep_pend) begin
                     state      <= ST_SLEEP;
                     sleeping   <= 1'b1;
                     sleep_pend <= 1'b0;
                  end
               end
               if (fire_in) begin
                  if (is_mul_op(op)) begin
                     state <= ST_BUSY;
                     op_q  <= op;
                  end else begin
                     result     <= alu_res;
                     flags_q    <= alu_flags;
                     out_valid  <= 1'b1;
                     sleep_pend <= (op == OP_SLEEP);
                     if (op == OP_CLRACC)
                        acc <= '0;
                  end
               end
            end
            ST_BUSY: begin
               if (mul_done) begin
                  result    <= busy_res;
                  flags_q   <= busy_flags;
                  out_valid <= 1'b1;
                  state     <= ST_IDLE;
                  if (op_q == OP_MAC)
                     acc <= mac_acc;
               end
            end
            ST_SLEEP: begin
               if (fire_in && (op == OP_WAKE)) begin
                  result    <= alu_res;
                  flags_q   <= alu_flags;
                  out_valid <= 1'b1;
                  state     <= ST_IDLE;
                  sleeping  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iot_alu_seq.sv
// Directed self-checking bench for iot_alu_seq (WIDTH=32, MUL_BPC=1).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_iot_alu_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        negative;
   logic        carry;
   logic        overflow;
   logic        sleeping;

   int n_chk;
   int n_pass;

   iot_alu_seq #(
      .WIDTH   (32),
      .MUL_BPC (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .negative  (negative),
      .carry     (carry),
      .overflow  (overflow),
      .sleeping  (sleeping)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request and hold it until accepted (bounded).
   task automatic send(input logic [3:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
      int n;
      n = 0;
      op = o;
      a = x;
      b = y;
      in_valid = 1'b1;
      while (!in_ready && n < 60) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         n_chk++;
         $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      int n;
      n = 0;
      while (!out_valid && n < 60) begin
         tick();
         n++;
      end
      ok = out_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      op = 4'h0;
      a = '0;
      b = '0;
      out_ready = 1'b1;
      #3;
      n_chk++;
      if ({in_ready, out_valid, sleeping} !== 3'b100)
         $display("FAIL rst_hs: got %b want 100",
                  {in_ready, out_valid, sleeping});
      else n_pass++;
      n_chk++;
      if ({result, zero, negative, carry, overflow} !== 36'h0)
         $display("FAIL rst_res: got %h/%b want 0/0000", result,
                  {zero, negative, carry, overflow});
      else n_pass++;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add();
      send(4'h0, 32'h7FFF_FFFF, 32'h1);
      n_chk++;
      if (out_valid !== 1'b1 || result !== 32'h8000_0000)
         $display("FAIL add_res: got %b/%h want 1/80000000",
                  out_valid, result);
      else n_pass++;
      n_chk++;
      if ({zero, negative, carry, overflow} !== 4'b0101)
         $display("FAIL add_flags: got %b want 0101",
                  {zero, negative, carry, overflow});
      else n_pass++;
      tick();
      n_chk++;
      if (out_valid !== 1'b0)
         $display("FAIL add_drop: out_valid=%b want 0", out_valid);
      else n_pass++;
      send(4'h0, 32'hFFFF_FFFF, 32'h1);
      n_chk++;
      if (result !== 32'h0 || {zero, negative, carry, overflow} !== 4'b1010)
         $display("FAIL add_carry: got %h/%b want 0/1010", result,
                  {zero, negative, carry, overflow});
      else n_pass++;
      tick();
   endtask

   task automatic test_sub_slt();
      op = 4'h1;
      a = 32'd5;
      b = 32'd5;
      in_valid = 1'b1;
      tick();
      n_chk++;
      if (result !== 32'h0 || {zero, negative, carry, overflow} !== 4'b1010)
         $display("FAIL sub_eq: got %h/%b want 0/1010", result,
                  {zero, negative, carry, overflow});
      else n_pass++;
      op = 4'h4;
      a = 32'hFFFF_FFFF;
      b = 32'h1;
      tick();
      in_valid = 1'b0;
      n_chk++;
      if (out_valid !== 1'b1 || result !== 32'h1 || carry !== 1'b0)
         $display("FAIL slt: got %b/%h/%b want 1/00000001/0",
                  out_valid, result, carry);
      else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ops [5];
      logic [31:0] exp [5];
      ops = '{4'h2, 4'h3, 4'h6, 4'h7, 4'hC};
      exp = '{32'h00F0_0034, 32'hFFF0_12FF, 32'hF000_1200,
              32'hF0FF_FF34, 32'h0};
      a = 32'hF0F0_1234;
      b = 32'h0FF0_00FF;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         op = ops[i];
         tick();
         n_chk++;
         if (out_valid !== 1'b1 || result !== exp[i])
            $display("FAIL b2b_op%0h: got %b/%h want 1/%h",
                     ops[i], out_valid, result, exp[i]);
         else n_pass++;
      end
      in_valid = 1'b0;
      n_chk++;
      if (zero !== 1'b1)
         $display("FAIL b2b_zero: zero=%b want 1", zero);
      else n_pass++;
      tick();
   endtask

   task automatic test_mul();
      int bad;
      bad = 0;
      send(4'hA, 32'd3, 32'd7);
      for (int i = 0; i < 32; i++) begin
         if (in_ready !== 1'b0 || out_valid !== 1'b0)
            bad++;
         tick();
      end
      n_chk++;
      if (bad != 0)
         $display("FAIL mul_busy: %0d busy cycles wrong, want 0", bad);
      else n_pass++;
      n_chk++;
      if (out_valid !== 1'b0)
         $display("FAIL mul_early: out_valid=%b want 0", out_valid);
      else n_pass++;
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || result !== 32'd21)
         $display("FAIL mul_res: got %b/%0d want 1/21",
                  out_valid, result);
      else n_pass++;
      tick();
   endtask

   task automatic test_mac();
      logic [3:0]  ops [4];
      logic [31:0] xa  [4];
      logic [31:0] xb  [4];
      logic [31:0] exp [4];
      bit ok;
      ops = '{4'h5, 4'h5, 4'hB, 4'h5};
      xa  = '{32'd2, 32'd4, 32'd0, 32'd1};
      xb  = '{32'd3, 32'd5, 32'd0, 32'd1};
      exp = '{32'd6, 32'd26, 32'd0, 32'd1};
      for (int i = 0; i < 4; i++) begin
         send(ops[i], xa[i], xb[i]);
         wait_out(ok);
         n_chk++;
         if (!ok || result !== exp[i] || overflow !== 1'b0)
            $display("FAIL mac_%0d: got %b/%0d/%b want 1/%0d/0",
                     i, ok, result, overflow, exp[i]);
         else n_pass++;
      end
      tick();
   endtask

   task automatic test_sleep();
      send(4'h8, 32'hDEAD, 32'h0);
      n_chk++;
      if (out_valid !== 1'b1 || result !== 32'h0 || sleeping !== 1'b0)
         $display("FAIL sleep_res: got %b/%h/%b want 1/0/0",
                  out_valid, result, sleeping);
      else n_pass++;
      tick();
      n_chk++;
      if ({sleeping, out_valid, in_ready} !== 3'b101)
         $display("FAIL sleep_state: got %b want 101",
                  {sleeping, out_valid, in_ready});
      else n_pass++;
      send(4'h0, 32'd1, 32'd1);
      tick();
      n_chk++;
      if (out_valid !== 1'b0 || sleeping !== 1'b1)
         $display("FAIL sleep_add: got %b/%b want 0/1",
                  out_valid, sleeping);
      else n_pass++;
      send(4'h9, 32'h1234, 32'h0);
      n_chk++;
      if (out_valid !== 1'b1 || result !== 32'h1234 || sleeping !== 1'b0)
         $display("FAIL wake: got %b/%h/%b want 1/1234/0",
                  out_valid, result, sleeping);
      else n_pass++;
      tick();
   endtask

   task automatic test_hold_reset();
      int bad;
      bit ok;
      bad = 0;
      out_ready = 1'b0;
      send(4'h0, 32'd10, 32'd20);
      op = 4'h1;
      a = 32'd1;
      b = 32'd1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || result !== 32'd30 || in_ready !== 1'b0)
            bad++;
         tick();
      end
      in_valid = 1'b0;
      n_chk++;
      if (bad != 0 || result !== 32'd30)
         $display("FAIL hold: %0d bad cycles, result %0d want 0/30",
                  bad, result);
      else n_pass++;
      out_ready = 1'b1;
      tick();
      n_chk++;
      if (out_valid !== 1'b0)
         $display("FAIL hold_rel: out_valid=%b want 0", out_valid);
      else n_pass++;
      send(4'h5, 32'd2, 32'd2);
      wait_out(ok);
      n_chk++;
      if (!ok || result !== 32'd5)
         $display("FAIL mac_pre: got %b/%0d want 1/5", ok, result);
      else n_pass++;
      tick();
      send(4'hA, 32'd5, 32'd5);
      repeat (10) tick();
      rst_n = 1'b0;
      #2;
      n_chk++;
      if ({in_ready, out_valid, sleeping} !== 3'b100 || result !== 32'h0)
         $display("FAIL rst_mid: got %b/%h want 100/0",
                  {in_ready, out_valid, sleeping}, result);
      else n_pass++;
      tick();
      rst_n = 1'b1;
      repeat (40) tick();
      n_chk++;
      if (out_valid !== 1'b0)
         $display("FAIL rst_stale: out_valid=%b want 0", out_valid);
      else n_pass++;
      send(4'h5, 32'd1, 32'd1);
      wait_out(ok);
      n_chk++;
      if (!ok || result !== 32'd1)
         $display("FAIL rst_acc: got %b/%0d want 1/1", ok, result);
      else n_pass++;
      tick();
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      test_reset();
      test_add();
      test_sub_slt();
      test_back_to_back();
      test_mul();
      test_mac();
      test_sleep();
      test_hold_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/iot_alu_seq.md
Name: iot_alu_seq

Overview:
- Parametrised, sequential successor to the single-cycle IoT ALU in the RISC-V execute stage.
- Adds valid/ready handshakes on both sides, an iterative multi-cycle multiplier, and a persistent MAC accumulator register.
- Adds a real SLEEP/WAKE power state; the ALU condition flags are kept.
- Sits between the ID/EX pipeline register and the EX/MEM register. EX stalls on in_ready low.

Parameters:
- WIDTH, 32: operand, result and accumulator width; must be ≥ 8.
- MUL_BPC, 1: multiplier bits retired per cycle; must divide WIDTH. Multiply latency is WIDTH/MUL_BPC cycles.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- op  in  4  opcode (see Behaviour)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- negative  out  1  result MSB
- carry  out  1  carry-out (ADD/SUB only, else 0)
- overflow  out  1  signed overflow (ADD/SUB only, else 0)
- sleeping  out  1  block is in the SLEEP state

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, result=0, all flags 0, sleeping=0. Accumulator cleared; state IDLE.
- Opcodes:
  - 0 ADD: a+b
  - 1 SUB: a+~b+1
  - 2 AND
  - 3 OR
  - 4 SLT: signed compare, result 1 or 0
  - 5 MAC: acc=acc+a*b, low WIDTH bits; result=new acc
  - 6 ANDN: a&~b
  - 7 ORN: a|~b
  - 8 SLEEP: result 0
  - 9 WAKE: result=a
  - A MUL: low WIDTH bits of a*b, unsigned
  - B CLRACC: acc=0, result 0
  - C–F: result 0, flags computed normally
- Transfer rule: a request transfers on in_valid&&in_ready. The output transfers on out_valid&&out_ready.
- States:
  - IDLE: in_ready=!out_valid || out_ready.
    - Single-cycle ops: result and flags registered; out_valid=1 the next cycle (latency 1). Back-to-back throughput is 1/cycle when out_ready=1.
    - MUL/MAC: operands latched, go to BUSY.
    - SLEEP: result 0 registered, go to SLEEP after the output is accepted.
  - BUSY: in_ready=0. The multiplier runs WIDTH/MUL_BPC cycles, then result and flags are registered and out_valid is raised.
    - Total latency from accept to out_valid is WIDTH/MUL_BPC+1 cycles.
    - For MAC, acc is updated in the same cycle result is registered. Return to IDLE.
  - SLEEP: sleeping=1, in_ready=1, multiplier and operand registers clock-gated/held.
    - Any op other than WAKE is consumed silently: no out_valid, acc unchanged.
    - WAKE: result=a, out_valid next cycle, go to IDLE, sleeping=0 in the same cycle out_valid rises.
- Output hold: result and flags stay stable while out_valid=1 and out_ready=0. No new request is accepted in that case.
- Flags:
  - zero and negative are derived from the registered result.
  - carry is bit WIDTH of the (WIDTH+1)-bit sum.
  - ADD overflow: a,b same sign and result sign differs from a.
  - SUB overflow: a,b signs differ and result sign differs from a.
- Reset mid-operation (BUSY or SLEEP): immediate return to the reset state. Accumulator cleared; the partial product is discarded.
- A MAC output not yet accepted still commits acc; a subsequent op sees the updated acc.

Optional Feature:
- IOT_ALU_ACC_SAT_EN defined:
  - MAC treats acc and the product as signed WIDTH-bit values.
  - On signed overflow, acc saturates to +2^(WIDTH-1)-1 or -2^(WIDTH-1).
  - overflow=1 on the saturating MAC output.
- Undefined: MAC wraps modulo 2^WIDTH and overflow=0.

Decomposition:
- Package iot_alu_pkg: 4-bit opcode localparams (OP_ADD..OP_CLRACC), state encoding (ST_IDLE, ST_BUSY, ST_SLEEP), and a flag-bundle struct.
- One sub-module, iot_mul_iter, the iterative shift-add multiplier:
  - params WIDTH, MUL_BPC
  - ports start, a, b, done, product (low WIDTH bits)

Test Plan:
- ADD a=0x7FFFFFFF, b=1, out_ready=1 -> next cycle result=0x80000000, overflow=1, negative=1, carry=0, zero=0.
- SUB a=5, b=5, then SLT a=0xFFFFFFFF, b=1 -> result=0, zero=1, carry=1; then result=1.
- MUL a=3, b=7, WIDTH=32, MUL_BPC=1 -> in_ready low 32 cycles, out_valid at cycle 33, result=21.
- MAC 2×3, then MAC 4×5 -> results 6 then 26; CLRACC -> 0; MAC 1×1 -> 1.
- SLEEP, then ADD 1+1, then WAKE a=0x1234 -> SLEEP result 0, sleeping=1; ADD produces no out_valid; WAKE result=0x1234, sleeping=0.
- out_ready held 0 for 5 cycles after ADD; rst_n pulsed low mid-MUL -> result stable and in_ready=0 during hold; after reset out_valid=0, in_ready=1, acc=0.
